// File: rtl/fx_bus_pkg.sv
// Shared constants, state encoding and small helpers for the fx bus master.
package fx_bus_pkg;

    // Frame sync bytes (defaults; the top exposes them as parameters)
    localparam logic [7:0] SYNC_CMD_DFLT = 8'hA5;
    localparam logic [7:0] SYNC_RSP_DFLT = 8'h5A;

    // Command opcodes
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    // Command decoder states
    typedef enum logic [3:0] {
        ST_HUNT   = 4'd0,
        ST_CMD    = 4'd1,
        ST_ADDR_H = 4'd2,
        ST_ADDR_L = 4'd3,
        ST_DATA   = 4'd4,
        ST_WR     = 4'd5,
        ST_RD     = 4'd6,
        ST_CAP    = 4'd7,
        ST_TX     = 4'd8
    } fx_state_e;

    // True for the states that take bytes from the receive stream
    function automatic logic rx_open(input fx_state_e st);
        logic open;
        case (st)
            ST_HUNT, ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_DATA: open = 1'b1;
            default:                                        open = 1'b0;
        endcase
        return open;
    endfunction

    // Saturating 8-bit increment; the error counter must never wrap
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'h01;
        end
        return r;
    endfunction

    // Select response byte idx (0 = first on the wire) from a packed frame
    function automatic logic [7:0] rsp_byte(input logic [31:0] frame, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = frame[31:24];
            2'd1:    b = frame[23:16];
            2'd2:    b = frame[15:8];
            2'd3:    b = frame[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fx_bus_master_tx_ser.sv
// Four-byte response serializer: loads a packed frame, presents one byte at a
// time on a valid/ready handshake and pulses done on the last handshake.
module fx_tx_ser
    import fx_bus_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] frame_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    output logic        done_o
);

    logic [31:0] frame_q, frame_d;
    logic [1:0]  idx_q, idx_d;
    logic        vld_q, vld_d;
    logic [7:0]  data_q, data_d;
    logic        done_s;

    // Next-state: load a new frame, or advance one byte per handshake
    always_comb begin
        frame_d = frame_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        data_d  = data_q;
        done_s  = 1'b0;
        if (load_i) begin
            frame_d = frame_i;
            idx_d   = 2'd0;
            vld_d   = 1'b1;
            data_d  = rsp_byte(frame_i, 2'd0);
        end else if (vld_q && tx_rdy_i) begin
            if (idx_q == 2'd3) begin
                // Last byte consumed: drop valid and return data to idle zero
                idx_d  = 2'd0;
                vld_d  = 1'b0;
                data_d = 8'h00;
                done_s = 1'b1;
            end else begin
                idx_d  = idx_q + 2'd1;
                data_d = rsp_byte(frame_q, idx_q + 2'd1);
            end
        end else begin
            // Stalled or idle: hold the presented byte
            data_d = data_q;
        end
    end

    // Serializer registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 32'h0000_0000;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            frame_q <= frame_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    assign tx_data_o = data_q;
    assign tx_vld_o  = vld_q;
    // Combinational so the parent leaves TX on the same edge as the last handshake
    assign done_o    = done_s;

endmodule

// File: rtl/fx_bus_master.sv
// Command decoder between the FX byte stream and the fx register bus. Parses
// write/read command frames, drives single-cycle bus strobes and returns read
// data as a framed response through fx_tx_ser.
module fx_bus_master
    import fx_bus_pkg::*;
#(
    parameter logic [7:0] SYNC_CMD = SYNC_CMD_DFLT,
    parameter logic [7:0] SYNC_RSP = SYNC_RSP_DFLT
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [15:0] fx_waddr,
    output logic [7:0]  fx_data,
    output logic        fx_wr,
    output logic [15:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic [7:0]  err_cnt
);

    fx_state_e   state_q, state_d;
    logic        is_rd_q, is_rd_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [7:0]  addr_lo_q, addr_lo_d;
    logic [15:0] fx_waddr_q, fx_waddr_d;
    logic [7:0]  fx_data_q, fx_data_d;
    logic [15:0] fx_raddr_q, fx_raddr_d;
    logic        fx_wr_q, fx_wr_d;
    logic        fx_rd_q, fx_rd_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        rx_acc_s;
    logic        tx_load_s;
    logic        tx_done_s;
    logic [31:0] tx_frame_s;

    // A byte is taken only when we advertise ready and the FIFO offers one
    assign rx_acc_s = rx_vld & rx_rdy_q;

    // Response frame; fx_q is sampled straight into the serializer in CAP
    assign tx_frame_s = {SYNC_RSP, fx_raddr_q, fx_q};

    // Next-state and datapath decode for the command FSM
    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        addr_hi_d  = addr_hi_q;
        addr_lo_d  = addr_lo_q;
        fx_waddr_d = fx_waddr_q;
        fx_data_d  = fx_data_q;
        fx_raddr_d = fx_raddr_q;
        err_cnt_d  = err_cnt_q;
        fx_wr_d    = 1'b0;
        fx_rd_d    = 1'b0;
        tx_load_s  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_acc_s && (rx_data == SYNC_CMD)) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_CMD: begin
                if (rx_acc_s) begin
                    if (rx_data == CMD_WR) begin
                        is_rd_d = 1'b0;
                        state_d = ST_ADDR_H;
                    end else if (rx_data == CMD_RD) begin
                        is_rd_d = 1'b1;
                        state_d = ST_ADDR_H;
                    end else begin
                        err_cnt_d = sat_inc8(err_cnt_q);
                        state_d   = ST_HUNT;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_ADDR_H: begin
                if (rx_acc_s) begin
                    addr_hi_d = rx_data;
                    state_d   = ST_ADDR_L;
                end else begin
                    state_d = ST_ADDR_H;
                end
            end
            ST_ADDR_L: begin
                if (rx_acc_s) begin
                    addr_lo_d = rx_data;
                    if (is_rd_q) begin
                        // Read address is complete: strobe the slave next cycle
                        fx_raddr_d = {addr_hi_q, rx_data};
                        fx_rd_d    = 1'b1;
                        state_d    = ST_RD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_ADDR_L;
                end
            end
            ST_DATA: begin
                if (rx_acc_s) begin
                    // Whole write frame decoded: publish address/data with the strobe
                    fx_waddr_d = {addr_hi_q, addr_lo_q};
                    fx_data_d  = rx_data;
                    fx_wr_d    = 1'b1;
                    state_d    = ST_WR;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WR: begin
                state_d = ST_HUNT;
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // Slave data is valid this cycle only
                tx_load_s = 1'b1;
                state_d   = ST_TX;
            end
            ST_TX: begin
                if (tx_done_s) begin
                    state_d = ST_HUNT;
                end else begin
                    state_d = ST_TX;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        rx_rdy_d = rx_open(state_d);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            is_rd_q    <= 1'b0;
            addr_hi_q  <= 8'h00;
            addr_lo_q  <= 8'h00;
            fx_waddr_q <= 16'h0000;
            fx_data_q  <= 8'h00;
            fx_raddr_q <= 16'h0000;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            rx_rdy_q   <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            is_rd_q    <= is_rd_d;
            addr_hi_q  <= addr_hi_d;
            addr_lo_q  <= addr_lo_d;
            fx_waddr_q <= fx_waddr_d;
            fx_data_q  <= fx_data_d;
            fx_raddr_q <= fx_raddr_d;
            fx_wr_q    <= fx_wr_d;
            fx_rd_q    <= fx_rd_d;
            rx_rdy_q   <= rx_rdy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    fx_tx_ser u_tx_ser (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .load_i    (tx_load_s),
        .frame_i   (tx_frame_s),
        .tx_data_o (tx_data),
        .tx_vld_o  (tx_vld),
        .tx_rdy_i  (tx_rdy),
        .done_o    (tx_done_s)
    );

    assign rx_rdy   = rx_rdy_q;
    assign fx_waddr = fx_waddr_q;
    assign fx_data  = fx_data_q;
    assign fx_wr    = fx_wr_q;
    assign fx_raddr = fx_raddr_q;
    assign fx_rd    = fx_rd_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fx_bus_master.sv
// Directed bench for fx_bus_master with a small cfg-register slave at mod_id 2.
module tb_fx_bus_master;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [15:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_wr;
    logic [15:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    // Slave model bookkeeping
    logic [7:0]  cfg [0:255];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [15:0] last_waddr = 16'h0000;
    logic [7:0]  last_wdata = 8'h00;

    fx_bus_master dut (
        .clk_sys  (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .rx_rdy   (rx_rdy),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .tx_rdy   (tx_rdy),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_wr    (fx_wr),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] slave_read(input logic [15:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a[13:8] == 6'd2) begin
            if (a[7:0] == 8'h10) r = 8'h55;
            else                 r = cfg[a[7:0]];
        end
        return r;
    endfunction

    // Registered cfg slave: mod_id 2, dev_id at register 8'h10, unmapped reads 0
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) cfg[i] <= 8'h00;
            fx_q <= 8'h00;
        end else begin
            fx_q <= fx_rd ? slave_read(fx_raddr) : 8'h00;
            if (fx_wr) begin
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= fx_waddr;
                last_wdata <= fx_data;
                if (fx_waddr[13:8] == 6'd2 && fx_waddr[7:0] != 8'h10)
                    cfg[fx_waddr[7:0]] <= fx_data;
            end
            if (fx_rd) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and return #1 after the edge that accepted it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_vld  = 1'b1;
        while (!rx_rdy && n < 50) begin
            step();
            n++;
        end
        chk("rx_accept", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(ah);
        send_byte(al);
    endtask

    // Collect a full response with tx_rdy held high
    task automatic recv_rsp(output logic [31:0] rsp, output int cycles, output logic rx_in_tx);
        int n;
        int k;
        n = 0;
        k = 0;
        rsp = 32'h0;
        rx_in_tx = 1'b0;
        tx_rdy = 1'b1;
        while (k < 4 && n < 100) begin
            if (tx_vld) begin
                rsp = {rsp[23:0], tx_data};
                k++;
                if (rx_rdy) rx_in_tx = 1'b1;
            end
            step();
            n++;
        end
        tx_rdy = 1'b0;
        cycles = n;
        chk("rsp_bytes", 64'(k), 64'd4);
    endtask

    task automatic wait_tx();
        int n;
        n = 0;
        while (!tx_vld && n < 20) begin
            step();
            n++;
        end
        chk("tx_wait", 64'(tx_vld), 64'd1);
    endtask

    initial begin
        logic [31:0] rsp;
        int          cyc;
        int          w0;
        int          r0;
        int          k;
        logic        rx_in_tx;
        logic        unstable;

        rx_data = 8'h00;
        rx_vld  = 1'b0;
        tx_rdy  = 1'b0;
        rst_n   = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_ctrl", {rx_rdy, tx_vld, tx_data, fx_wr, fx_rd}, 64'd0);
        chk("rst_addr", {fx_waddr, fx_raddr}, 64'd0);
        chk("rst_data", {fx_data, err_cnt}, 64'd0);
        rst_n = 1'b1;
        chk("rdy_before_edge", rx_rdy, 64'd0);
        step();
        chk("rdy_after_release", rx_rdy, 64'd1);

        // Write A5 01 02 80 3C and its timing
        w0 = wr_cnt;
        send_cmd(8'h01, 8'h02, 8'h80);
        send_byte(8'h3C);
        chk("wr_pulse", fx_wr, 64'd1);
        chk("wr_addr", fx_waddr, 64'h0280);
        chk("wr_data", fx_data, 64'h3C);
        chk("wr_rdy_low", rx_rdy, 64'd0);
        step();
        chk("wr_single", fx_wr, 64'd0);
        chk("wr_rdy_back", rx_rdy, 64'd1);
        chk("wr_count", 64'(wr_cnt - w0), 64'd1);

        // Read back 0280
        send_cmd(8'h02, 8'h02, 8'h80);
        recv_rsp(rsp, cyc, rx_in_tx);
        chk("rd_0280", rsp, 64'h5A02803C);

        // Read dev_id with exact latency
        r0 = rd_cnt;
        send_cmd(8'h02, 8'h02, 8'h10);
        chk("rd_n1_strobe", fx_rd, 64'd1);
        chk("rd_n1_addr", fx_raddr, 64'h0210);
        chk("rd_n1_txvld", tx_vld, 64'd0);
        step();
        chk("rd_n2_strobe", fx_rd, 64'd0);
        chk("rd_n2_txvld", tx_vld, 64'd0);
        chk("rd_n2_raddr", fx_raddr, 64'h0210);
        step();
        chk("rd_n3_txvld", tx_vld, 64'd1);
        chk("rd_n3_sync", tx_data, 64'h5A);
        chk("rd_count", 64'(rd_cnt - r0), 64'd1);
        recv_rsp(rsp, cyc, rx_in_tx);
        chk("rd_devid", rsp, 64'h5A021055);
        chk("tx_b2b_cycles", 64'(cyc), 64'd4);
        chk("rx_rdy_in_tx", rx_in_tx, 64'd0);

        // Bad command, then a valid read
        w0 = wr_cnt;
        r0 = rd_cnt;
        send_byte(8'hA5);
        send_byte(8'h07);
        step();
        chk("bad_err1", err_cnt, 64'd1);
        chk("bad_no_strobe", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
        send_cmd(8'h02, 8'h02, 8'h80);
        recv_rsp(rsp, cyc, rx_in_tx);
        chk("rd_after_bad", rsp, 64'h5A02803C);

        // 300 bad frames in total: reach and hold saturation
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hA5);
            send_byte(8'h07);
        end
        chk("err_sat_255", err_cnt, 64'hFF);
        for (int i = 0; i < 45; i++) begin
            send_byte(8'hA5);
            send_byte(8'h07);
        end
        chk("err_no_wrap", err_cnt, 64'hFF);

        // Garbage before a write
        w0 = wr_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_cmd(8'h01, 8'h05, 8'h81);
        send_byte(8'h11);
        step();
        chk("garb_count", 64'(wr_cnt - w0), 64'd1);
        chk("garb_addr", last_waddr, 64'h0581);
        chk("garb_data", last_wdata, 64'h11);

        // Sync byte inside payload is plain data
        send_cmd(8'h01, 8'hA5, 8'hA5);
        send_byte(8'hA5);
        chk("payload_sync", {fx_wr, fx_waddr, fx_data}, {1'b1, 16'hA5A5, 8'hA5});

        // Unmapped read returns zero data
        send_cmd(8'h02, 8'h03, 8'h10);
        recv_rsp(rsp, cyc, rx_in_tx);
        chk("rd_unmapped", rsp, 64'h5A031000);

        // Stall 20 cycles, then toggle tx_rdy
        send_cmd(8'h02, 8'h02, 8'h80);
        wait_tx();
        unstable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_vld !== 1'b1 || tx_data !== 8'h5A || rx_rdy !== 1'b0) unstable = 1'b1;
            step();
        end
        chk("stall_stable", unstable, 64'd0);
        rsp = 32'h0;
        k = 0;
        rx_in_tx = 1'b0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            tx_rdy = i[0];
            if (tx_vld && rx_rdy) rx_in_tx = 1'b1;
            if (tx_vld && tx_rdy) begin
                rsp = {rsp[23:0], tx_data};
                k++;
            end
            step();
        end
        tx_rdy = 1'b0;
        chk("toggle_count", 64'(k), 64'd4);
        chk("toggle_rsp", rsp, 64'h5A02803C);
        chk("toggle_rx_rdy", rx_in_tx, 64'd0);
        step();
        chk("toggle_done_idle", tx_vld, 64'd0);

        // Reset during ADDR_L of a write
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        rx_data = 8'h90;
        rx_vld  = 1'b1;
        rst_n   = 1'b0;
        #2;
        rx_vld = 1'b0;
        chk("rstA_ctrl", {rx_rdy, tx_vld, tx_data, fx_wr, fx_rd}, 64'd0);
        chk("rstA_addr", {fx_waddr, fx_raddr}, 64'd0);
        chk("rstA_data", {fx_data, err_cnt}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rstA_no_wr", 64'(wr_cnt - w0), 64'd0);
        send_byte(8'h90);
        send_byte(8'h3C);
        send_cmd(8'h01, 8'h02, 8'h81);
        send_byte(8'h77);
        chk("rstA_next", {fx_wr, fx_waddr, fx_data}, {1'b1, 16'h0281, 8'h77});
        step();
        chk("rstA_count", 64'(wr_cnt - w0), 64'd1);

        // Reset during TX
        send_cmd(8'h02, 8'h02, 8'h81);
        wait_tx();
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        chk("rstB_byte1", tx_data, 64'h02);
        rst_n = 1'b0;
        #1;
        chk("rstB_ctrl", {rx_rdy, tx_vld, tx_data, fx_wr, fx_rd}, 64'd0);
        chk("rstB_addr", {fx_waddr, fx_raddr}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        send_cmd(8'h02, 8'h02, 8'h81);
        recv_rsp(rsp, cyc, rx_in_tx);
        chk("rstB_next_rd", rsp, 64'h5A028100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
